// File: rtl/rx_line_assembler_if.sv
// Byte-in / line-out bundle for rx_line_assembler.
// master = assembler side, slave = UART/consumer side.
interface rx_line_assembler_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  logic [7:0]           in_byte;
  logic                 in_valid;
  logic [8*MAX_LEN-1:0] line_data;
  logic [LEN_W-1:0]     line_len;
  logic                 line_valid;
  logic                 line_ready;
  logic                 line_overflow;
  logic                 line_dropped;
  logic [7:0]           out_byte;

  modport master (
    input  in_byte,
    input  in_valid,
    input  line_ready,
    output line_data,
    output line_len,
    output line_valid,
    output line_overflow,
    output line_dropped,
    output out_byte
  );

  modport slave (
    output in_byte,
    output in_valid,
    output line_ready,
    input  line_data,
    input  line_len,
    input  line_valid,
    input  line_overflow,
    input  line_dropped,
    input  out_byte
  );
endinterface

// File: rtl/rx_line_assembler.sv
// Assembles UART RX bytes into CR/LF terminated lines
// and hands them out through a valid/ready register.
module rx_line_assembler #(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter int DROP_EMPTY = 1
) (
  input logic              clk_line_asm,
  input logic              rst_line_asm,
  rx_line_assembler_if.master bus
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  localparam int              DW      = 8 * MAX_LEN;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  logic [0:0]       state;
  logic [DW-1:0]    buf_q;
  logic [LEN_W-1:0] count;

  logic [DW-1:0]    data_q;
  logic [LEN_W-1:0] len_q;
  logic             valid_q;
  logic             ovf_q;
  logic             drop_q;
  logic [7:0]       last_q;

  logic             is_term;
  logic             in_col;
  logic             empty;
  logic             complete;
  logic             out_free;
  logic             load;
  logic             drop;
  logic             store;
  logic             ovf;
  logic [DW-1:0]    masked;

  assign is_term  = (bus.in_byte == 8'h0D)
                 || (bus.in_byte == 8'h0A);
  assign in_col   = bus.in_valid && (state == COLLECT);
  assign empty    = (count == '0) && (DROP_EMPTY != 0);
  assign complete = in_col && is_term && !empty;
  assign out_free = !valid_q || bus.line_ready;
  assign load     = complete && out_free;
  assign drop     = complete && !out_free;
  assign store    = in_col && !is_term && (count < MAX_CNT);
  assign ovf      = in_col && !is_term && (count == MAX_CNT);

  // Stale bytes from earlier longer lines must not leak out.
  always_comb begin
    masked = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (LEN_W'(k) < count)
        masked[8*k +: 8] = buf_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk_line_asm or posedge rst_line_asm) begin
    if (rst_line_asm) begin
      state <= COLLECT;
      count <= '0;
      buf_q <= '0;
    end else if (bus.in_valid) begin
      unique case (state)
        COLLECT: begin
          if (is_term) begin
            count <= '0;
          end else if (count < MAX_CNT) begin
            count <= count + 1'b1;
          end else begin
            state <= DISCARD;
            count <= '0;
          end
        end
        DISCARD: begin
          if (is_term)
            state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
      for (int k = 0; k < MAX_LEN; k++) begin
        if (store && (count == LEN_W'(k)))
          buf_q[8*k +: 8] <= bus.in_byte;
      end
    end
  end

  always_ff @(posedge clk_line_asm or posedge rst_line_asm) begin
    if (rst_line_asm) begin
      data_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      last_q  <= 8'h00;
    end else begin
      ovf_q  <= ovf;
      drop_q <= drop;
      if (load) begin
        data_q  <= masked;
        len_q   <= count;
        valid_q <= 1'b1;
      end else if (valid_q && bus.line_ready) begin
        valid_q <= 1'b0;
      end
      if (bus.in_valid && !is_term)
        last_q <= bus.in_byte;
    end
  end

  assign bus.line_data     = data_q;
  assign bus.line_len      = len_q;
  assign bus.line_valid    = valid_q;
  assign bus.line_overflow = ovf_q;
  assign bus.line_dropped  = drop_q;
  assign bus.out_byte      = last_q;

endmodule
